// File: rtl/ps2_num_entry_pkg.sv
// Shared constants for the PS2 number-entry block: scancodes, FSM states, MMIO map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_num_entry_pkg;

  // PS2 set-2 make codes for the control keys
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Number Buffer MMIO window read by the CPU
  localparam logic [31:0] NUM_BUF_ADDR   = 32'h5000_0000;
  localparam logic [31:0] NUM_VALID_ADDR = 32'h5000_0004;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // acc*10 + d, built from shifts so no multiplier is inferred
  function automatic logic [31:0] mul10_add(input logic [31:0] acc, input logic [3:0] d);
    return (acc << 3) + (acc << 1) + {28'd0, d};
  endfunction

endpackage

// File: rtl/ps2_digit_decode.sv
// Maps a PS2 set-2 make code to a decimal digit (main row and keypad).
// Latency: combinational.
// Backpressure: none.
module ps2_digit_decode (
  input  logic [7:0] i_scancode,
  output logic       o_is_digit,
  output logic [3:0] o_digit
);

  // Table lookup; anything not a digit key reports is_digit=0
  always_comb begin
    o_is_digit = 1'b1;
    o_digit    = 4'd0;
    case (i_scancode)
      8'h45, 8'h70: o_digit = 4'd0;
      8'h16, 8'h69: o_digit = 4'd1;
      8'h1E, 8'h72: o_digit = 4'd2;
      8'h26, 8'h7A: o_digit = 4'd3;
      8'h25, 8'h6B: o_digit = 4'd4;
      8'h2E, 8'h73: o_digit = 4'd5;
      8'h36, 8'h74: o_digit = 4'd6;
      8'h3D, 8'h6C: o_digit = 4'd7;
      8'h3E, 8'h75: o_digit = 4'd8;
      8'h46, 8'h7D: o_digit = 4'd9;
      default:      o_is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_num_entry.sv
// PS2 digit keystrokes -> BCD entry stack -> 32-bit binary value with valid flag.
// Latency: Enter edge to num_valid_out high is digit_count+1 cycles.
// Backpressure: value is held in HOLD until num_ack; keys are dropped while busy or holding.
module ps2_num_entry
  import ps2_num_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              ps2_scancode_in,
  input  logic                    ps2_key_pressed_in,
  input  logic                    num_ack,
  output logic [31:0]             num_buffer_out,
  output logic                    num_valid_out,
  output logic [4*MAX_DIGITS-1:0] digits_bcd_out,
  output logic [CNT_W-1:0]        digit_count_out,
  output logic                    busy_out
);

  localparam int BCD_W = 4 * MAX_DIGITS;

  // More than 9 digits could overflow the 32-bit accumulator
  if (MAX_DIGITS < 1 || MAX_DIGITS > 9) begin : g_bad_max_digits
    $error("ps2_num_entry: MAX_DIGITS must be in 1..9");
  end
  if ((1 << CNT_W) <= MAX_DIGITS) begin : g_bad_cnt_w
    $error("ps2_num_entry: CNT_W too narrow for MAX_DIGITS");
  end

  state_t             r_state, w_next;
  logic               r_key_prev;
  logic               w_key_evt;
  logic               w_is_digit;
  logic [3:0]         w_digit;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  // r_left = digits still to fold in; the digit used is index r_left-1.
  // Reaching 0 leaves one extra cycle to commit, giving count+1 latency.
  logic [CNT_W-1:0]   r_left;
  logic [31:0]        r_acc;
  logic [31:0]        r_buf;
  logic [3:0]         w_sel_digit;
  logic               w_take, w_bksp, w_esc, w_start, w_step, w_commit, w_clear;
  logic               w_busy, w_valid;

  ps2_digit_decode u_decode (
    .i_scancode (ps2_scancode_in),
    .o_is_digit (w_is_digit),
    .o_digit    (w_digit)
  );

  // Remember last key level so only the press edge counts as an event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_key_prev <= 1'b0;
    else      r_key_prev <= ps2_key_pressed_in;
  end

  assign w_key_evt = ps2_key_pressed_in & ~r_key_prev;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_next = ST_CONVERT;
      ST_CONVERT: if (r_left == '0) w_next = ST_HOLD;
      ST_HOLD:    if (num_ack) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: one datapath strobe per action; keys only act in IDLE
  always_comb begin
    w_take   = 1'b0;
    w_bksp   = 1'b0;
    w_esc    = 1'b0;
    w_start  = 1'b0;
    w_step   = 1'b0;
    w_commit = 1'b0;
    w_clear  = 1'b0;
    w_busy   = 1'b0;
    w_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_key_evt) begin
          if (w_is_digit)                                  w_take  = (r_cnt < CNT_W'(MAX_DIGITS));
          else if (ps2_scancode_in == SC_BKSP)             w_bksp  = (r_cnt != '0);
          else if (ps2_scancode_in == SC_ESC)              w_esc   = 1'b1;
          else if (ps2_scancode_in == SC_ENTER)            w_start = (r_cnt != '0);
        end
      end
      ST_CONVERT: begin
        w_busy   = 1'b1;
        w_step   = (r_left != '0);
        w_commit = (r_left == '0);
      end
      ST_HOLD: begin
        w_valid = 1'b1;
        w_clear = num_ack;
      end
      default: ;
    endcase
  end

  // Pick the digit being folded in this CONVERT cycle
  always_comb begin
    w_sel_digit = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (r_left == CNT_W'(i + 1)) w_sel_digit = r_bcd[4*i +: 4];
    end
  end

  // BCD entry stack and digit count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_bcd <= {r_bcd[BCD_W-5:0], w_digit};
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_bksp) begin
      r_bcd <= {4'd0, r_bcd[BCD_W-1:4]};
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (w_esc || w_clear) begin
      r_bcd <= '0;
      r_cnt <= '0;
    end
  end

  // BCD-to-binary accumulator, most significant digit first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_left <= '0;
    end else if (w_start) begin
      r_acc  <= '0;
      r_left <= r_cnt;
    end else if (w_step) begin
      r_acc  <= mul10_add(r_acc, w_sel_digit);
      r_left <= r_left - CNT_W'(1);
    end
  end

  // Committed value; only written once conversion completes, cleared on ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_buf <= '0;
    else if (w_commit) r_buf <= r_acc;
    else if (w_clear)  r_buf <= '0;
  end

  assign num_buffer_out  = r_buf;
  assign num_valid_out   = w_valid;
  assign busy_out        = w_busy;
  assign digits_bcd_out  = r_bcd;
  assign digit_count_out = r_cnt;

endmodule

// File: tb/tb_ps2_num_entry.sv
// Directed bench: committed values go through a scoreboard queue checked by a
// monitor on each num_valid_out rise (value and arrival cycle); entry state is
// checked directly by the stimulus thread.
module tb_ps2_num_entry;
  import ps2_num_entry_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ps2_scancode_in = 8'h00;
  logic        ps2_key_pressed_in = 1'b0;
  logic        num_ack = 1'b0;
  logic [31:0] num_buffer_out;
  logic        num_valid_out;
  logic [31:0] digits_bcd_out;
  logic [3:0]  digit_count_out;
  logic        busy_out;

  ps2_num_entry #(.MAX_DIGITS(8), .CNT_W(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .ps2_scancode_in    (ps2_scancode_in),
    .ps2_key_pressed_in (ps2_key_pressed_in),
    .num_ack            (num_ack),
    .num_buffer_out     (num_buffer_out),
    .num_valid_out      (num_valid_out),
    .digits_bcd_out     (digits_bcd_out),
    .digit_count_out    (digit_count_out),
    .busy_out           (busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rise of num_valid_out must match the oldest expectation
  always @(negedge clk) begin
    if (num_valid_out && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", num_buffer_out, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_value", num_buffer_out, e.val);
        chk("commit_cycle", cyc, e.cyc);
      end
    end
    prev_valid = num_valid_out;
  end

  task automatic press(input logic [7:0] code);
    @(negedge clk);
    ps2_scancode_in    = code;
    ps2_key_pressed_in = 1'b1;
    @(negedge clk);
    ps2_key_pressed_in = 1'b0;
    @(negedge clk);
  endtask

  // Enter with a scoreboard entry: valid expected count+1 edges after the Enter edge
  task automatic press_enter(input logic [31:0] val, input int unsigned ndig);
    exp_t e;
    @(negedge clk);
    e.val = val;
    e.cyc = cyc + 1 + ndig + 1;
    sb.push_back(e);
    ps2_scancode_in    = SC_ENTER;
    ps2_key_pressed_in = 1'b1;
    @(negedge clk);
    ps2_key_pressed_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk(name, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    num_ack = 1'b1;
    @(negedge clk);
    num_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 32'(num_valid_out), 32'd0);
    chk("rst_buf",   num_buffer_out, 32'd0);
    chk("rst_bcd",   digits_bcd_out, 32'd0);
    chk("rst_cnt",   32'(digit_count_out), 32'd0);
    chk("rst_busy",  32'(busy_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1,2,3 Enter -> 123
    press(8'h16); press(8'h1E); press(8'h26);
    chk("e123_bcd", 32'(digits_bcd_out[11:0]), 32'h123);
    chk("e123_cnt", 32'(digit_count_out), 32'd3);
    press_enter(32'd123, 3);
    chk("e123_busy", 32'(busy_out), 32'd1);
    wait_drain("e123_timeout", 20);
    chk("e123_buf_hold", num_buffer_out, 32'h7B);
    // Key in HOLD ignored
    press(8'h3E);
    chk("hold_key_cnt", 32'(digit_count_out), 32'd3);
    chk("hold_key_bcd", 32'(digits_bcd_out[11:0]), 32'h123);
    chk("hold_valid", 32'(num_valid_out), 32'd1);
    ack_pulse();
    chk("ack_valid", 32'(num_valid_out), 32'd0);
    chk("ack_buf",   num_buffer_out, 32'd0);
    chk("ack_cnt",   32'(digit_count_out), 32'd0);
    chk("ack_bcd",   digits_bcd_out, 32'd0);

    // Nine presses of 9 -> 8 digits accepted
    for (int i = 0; i < 9; i++) press(8'h46);
    chk("max_cnt", 32'(digit_count_out), 32'd8);
    chk("max_bcd", digits_bcd_out, 32'h9999_9999);
    press_enter(32'h05F5_E0FF, 8);
    wait_drain("max_timeout", 30);
    ack_pulse();

    // 4,5,Bksp,7 -> 47
    press(8'h25); press(8'h2E);
    press(SC_BKSP);
    chk("bksp_cnt", 32'(digit_count_out), 32'd1);
    press(8'h3D);
    chk("bksp_bcd", 32'(digits_bcd_out[7:0]), 32'h47);
    chk("bksp_cnt2", 32'(digit_count_out), 32'd2);
    press_enter(32'd47, 2);
    wait_drain("e47_timeout", 20);
    // ack and key edge in the same HOLD cycle: ack wins, key dropped
    @(negedge clk);
    num_ack            = 1'b1;
    ps2_scancode_in    = 8'h3D;
    ps2_key_pressed_in = 1'b1;
    @(negedge clk);
    num_ack            = 1'b0;
    ps2_key_pressed_in = 1'b0;
    @(negedge clk);
    chk("ackkey_cnt",   32'(digit_count_out), 32'd0);
    chk("ackkey_valid", 32'(num_valid_out), 32'd0);

    // Ack in IDLE is ignored; Esc clears; Enter at count 0 does nothing
    press(8'h16);
    ack_pulse();
    chk("idle_ack_cnt", 32'(digit_count_out), 32'd1);
    chk("idle_ack_bcd", 32'(digits_bcd_out[3:0]), 32'h1);
    press(SC_ESC);
    chk("esc_cnt", 32'(digit_count_out), 32'd0);
    chk("esc_bcd", digits_bcd_out, 32'd0);
    press(SC_ENTER);
    chk("empty_enter_busy", 32'(busy_out), 32'd0);
    repeat (12) @(negedge clk);
    chk("empty_enter_valid", 32'(num_valid_out), 32'd0);

    // Held key counts once; keypad 2
    @(negedge clk);
    ps2_scancode_in    = 8'h45;
    ps2_key_pressed_in = 1'b1;
    repeat (20) @(negedge clk);
    ps2_key_pressed_in = 1'b0;
    @(negedge clk);
    chk("held_cnt", 32'(digit_count_out), 32'd1);
    press(8'h72);
    chk("keypad_bcd", 32'(digits_bcd_out[7:0]), 32'h02);
    chk("keypad_cnt", 32'(digit_count_out), 32'd2);
    press_enter(32'd2, 2);
    wait_drain("e02_timeout", 20);
    ack_pulse();

    // Reset in the middle of converting 5678
    press(8'h2E); press(8'h36); press(8'h3D); press(8'h3E);
    press(SC_ENTER);
    chk("mid_busy", 32'(busy_out), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy",  32'(busy_out), 32'd0);
    chk("arst_valid", 32'(num_valid_out), 32'd0);
    chk("arst_buf",   num_buffer_out, 32'd0);
    chk("arst_cnt",   32'(digit_count_out), 32'd0);
    chk("arst_bcd",   digits_bcd_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_valid", 32'(num_valid_out), 32'd0);
    chk("post_rst_buf",   num_buffer_out, 32'd0);
    press(8'h2E);
    press_enter(32'd5, 1);
    wait_drain("e5_timeout", 20);
    ack_pulse();

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_num_entry.md
Name: ps2_num_entry

Overview:
Upstream feeder for the processor's Number Buffer MMIO window (0x50000000 value, 0x50000004 valid flag). Turns PS2 digit keystrokes into a decimal entry held as a BCD digit stack. On Enter, converts that entry to a 32-bit binary value and holds it with a valid flag until software acknowledges. Sits between the PS2 keyboard decoder and data_path's num_buffer_in/num_valid_in inputs.

Parameters:
MAX_DIGITS, 8, maximum decimal digits accepted; 8 guarantees the result fits 32 bits (max 99,999,999).
CNT_W, 4, width of digit_count; must hold MAX_DIGITS.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
ps2_scancode_in  input  8  PS2 set-2 make code, stable while ps2_key_pressed_in is high
ps2_key_pressed_in  input  1  level, high while a key is held
num_ack  input  1  one-cycle pulse from CPU-side logic: consume the value and clear the entry
num_buffer_out  output  32  binary value of the last committed entry
num_valid_out  output  1  committed value available
digits_bcd_out  output  4*MAX_DIGITS  current entry, digit 0 = least significant, for display
digit_count_out  output  CNT_W  number of digits entered
busy_out  output  1  conversion in progress

Behaviour:
- Reset (rst low, async): all outputs 0, BCD stack 0, FSM in IDLE.
- Key event: a rising edge of ps2_key_pressed_in, detected by a registered previous level. The scancode is sampled on the same clk edge. One event per press; held keys do not repeat.
- Digit codes: 0x45,16,1E,26,25,2E,36,3D,3E,46 map to 0..9. Keypad codes 0x70,69,72,7A,6B,73,74,6C,75,7D also map to 0..9. Enter = 0x5A, Backspace = 0x66, Esc = 0x76. All other codes are ignored.
- FSM states IDLE, CONVERT, HOLD.
- IDLE, digit key:
  - If digit_count < MAX_DIGITS: shift the stack left one digit, insert the new digit at position 0, count+1.
  - At MAX_DIGITS: ignore the key.
  - Leading zeros are stored and counted.
- IDLE, Backspace: shift the stack right one digit, top digit becomes 0, count-1. No effect at count 0.
- IDLE, Esc: clear the stack and set count to 0.
- IDLE, Enter: if count is 0, ignore. Otherwise load acc=0, idx=count-1, go to CONVERT, busy_out=1.
- CONVERT, one digit per cycle, MSB first:
  - acc <= (acc<<3) + (acc<<1) + digit[idx]; idx decrements.
  - After the digit[0] cycle, next edge: num_buffer_out <= acc, num_valid_out <= 1, busy_out <= 0, go to HOLD.
  - Latency from the Enter edge to num_valid_out high is count+1 cycles.
- CONVERT: all key events are dropped; edge detection still tracks the level.
- HOLD: key events are dropped. Stack and count are kept, so the display still shows the entry.
- num_ack:
  - In HOLD: next edge clears num_valid_out, num_buffer_out, stack and count; go to IDLE.
  - In IDLE or CONVERT: ignored.
  - If num_ack and a key edge occur in the same cycle in HOLD, the ack wins and the key is dropped.
- Arithmetic uses 32-bit unsigned. No overflow is possible at MAX_DIGITS <= 9. Synthesis asserts MAX_DIGITS <= 9.
- Reset mid-CONVERT: returns to the reset state immediately. No partial value reaches num_buffer_out.

Decomposition:
- Shared package/defines: scancode constants (SC_ENTER, SC_BKSP, SC_ESC), FSM state encodings, MMIO address constants NUM_BUF_ADDR and NUM_VALID_ADDR.
- One sub-module, ps2_digit_decode: combinational, scancode to {is_digit, digit[3:0]}, covering both main-row and keypad codes.

Test Plan:
- Reset, then press 1,2,3 (0x16,0x1E,0x26), then Enter -> digits_bcd_out[11:0]=0x123, count=3, num_valid_out rises 4 cycles after the Enter edge, num_buffer_out=123 (0x7B).
- Keys 9 x8, then a 9th press of 9, then Enter -> 9th key ignored, count=8, num_buffer_out=99,999,999 (0x05F5E0FF).
- Keys 4,5, Backspace, 7, Enter -> num_buffer_out=47. Separately: Esc, then Enter with count 0 -> no valid, FSM stays IDLE.
- Hold key 0x45 high for 20 cycles -> exactly one digit entered. Keypad 0x72 -> digit 2.
- In HOLD: press 8 -> ignored. Pulse num_ack -> next cycle num_valid_out=0, num_buffer_out=0, count=0. Pulse num_ack while IDLE -> no change.
- Assert rst low during CONVERT of "5678" -> all outputs 0 asynchronously. After release, entering "5" + Enter -> num_buffer_out=5.
